// File: rtl/rf_pkg.sv
// Register-file geometry and the writeback request record shared by the
// writeback arbiter and its users.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past the winner on every grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Outer loop walks priority order from the pointer; inner loop finds the
  // source sitting at that offset so every index stays a loop constant.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(ptr_q) + k) % N))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          ptr_d    = PW'((i + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port among NUM_SRC writeback sources and
// keeps the per-register pending bitmap used by issue for hazard stalls.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  input  logic                      alloc_valid,
  input  logic [ADDR_W-1:0]         alloc_rd,
  input  logic [ADDR_W-1:0]         rs1,
  input  logic [ADDR_W-1:0]         rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [NUM_REGS-1:0]       busy_vec
);

  wb_req_t [NUM_SRC-1:0] req;
  wb_req_t               sel;
  logic [NUM_SRC-1:0]    grant;
  logic                  any_grant;

  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign req[g].rd   = src_rd[g*ADDR_W +: ADDR_W];
    assign req[g].data = src_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .clock (clock),
    .reset (reset),
    .req   (src_valid),
    .grant (grant)
  );

  // The register file never stalls, so a grant is an acceptance.
  assign src_ready = reset ? '0 : grant;
  assign any_grant = |grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (grant[i]) sel = sel | req[i];
  end

  // x0 writebacks are consumed and still move write_reg/write_data, but never
  // raise the write enable.
  always_comb begin
    reg_write_d  = any_grant && (sel.rd != '0);
    write_reg_d  = any_grant ? sel.rd   : write_reg_q;
    write_data_d = any_grant ? sel.data : write_data_q;
  end

  // Clear lands with the register file capturing the data; a same-register
  // allocation on that edge is a new producer, so the set is applied last.
  always_comb begin
    pending_d = pending_q;
    if (reg_write_q) pending_d[write_reg_q] = 1'b0;
    if (alloc_valid && (alloc_rd != '0)) pending_d[alloc_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy_vec   = pending_q;
  assign rs1_busy   = pending_q[rs1];
  assign rs2_busy   = pending_q[rs2];

endmodule
